// File: rtl/ped_pkg.sv
// Shared definitions for the pedestrian pushbutton controller:
// the FSM state encoding, default timing constants and a saturating
// increment helper for the debounce counter.
package ped_pkg;

  // Debounce FSM states, fixed 2-bit encoding
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DB_PRESS   = 2'd1,
    HELD       = 2'd2,
    DB_RELEASE = 2'd3
  } ped_state_t;

  // Defaults assume a 12 MHz clock: 5 ms debounce, 1 s long press
  localparam logic [15:0] DEF_DEBOUNCE_CYCLES   = 16'd60_000;
  localparam logic [23:0] DEF_LONG_PRESS_CYCLES = 24'd12_000_000;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
// RESET_VAL sets the value both flops take during reset, so the
// synchronised output starts in the input's idle level.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the raw input through two flops to settle metastability
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ped_button_ctrl.sv
// Pedestrian pushbutton front end: synchronise the active-low button,
// debounce it with a four-state FSM, and produce a press pulse, a sticky
// crossing request and a press counter.
// Optional feature macro: PED_LONG_PRESS_EN adds a long_press pulse
// driven by a hold counter that runs while the button is held.
module ped_button_ctrl
  import ped_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter logic [23:0] LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       buton,
  input  logic       req_ack,
  output logic       btn_level,
  output logic       btn_press,
  output logic       req_pending,
  output logic [7:0] press_count
`ifdef PED_LONG_PRESS_EN
  ,
  output logic       long_press
`endif
);

  logic       buton_sync;
  logic       pressed_s;
  ped_state_t state;
  ped_state_t state_next;
  logic [15:0] db_cnt;
  logic [15:0] db_cnt_next;
  logic       db_done;

  // Button idles high (released), so the synchroniser resets to 1
  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (buton),
    .q   (buton_sync)
  );

  assign pressed_s = ~buton_sync;
  assign db_done   = (db_cnt == DEBOUNCE_CYCLES - 16'd1);

  // State and debounce counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      db_cnt <= 16'd0;
    end else begin
      state  <= state_next;
      db_cnt <= db_cnt_next;
    end
  end

  // Next-state logic; the counter only advances while staying in a
  // debounce state, and is cleared on every state change
  always_comb begin
    state_next  = state;
    db_cnt_next = 16'd0;
    case (state)
      IDLE:       if (pressed_s) state_next = DB_PRESS;
      DB_PRESS:   if (!pressed_s) state_next = IDLE;
                  else if (db_done) state_next = HELD;
      HELD:       if (!pressed_s) state_next = DB_RELEASE;
      DB_RELEASE: if (pressed_s) state_next = HELD;
                  else if (db_done) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
    if ((state == DB_PRESS || state == DB_RELEASE) && state_next == state)
      db_cnt_next = sat_inc16(db_cnt);
  end

  // Press pulse fires in the last stable DB_PRESS cycle, just before HELD
  always_comb begin
    btn_press = (state == DB_PRESS) && pressed_s && db_done;
  end

  // Debounced level registered from the upcoming state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) btn_level <= 1'b0;
    else     btn_level <= (state_next == HELD) || (state_next == DB_RELEASE);
  end

  // Sticky request: a new press wins over a same-cycle acknowledge
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            req_pending <= 1'b0;
    else if (btn_press) req_pending <= 1'b1;
    else if (req_ack)   req_pending <= 1'b0;
  end

  // Accepted-press counter, wraps naturally at 8 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            press_count <= 8'd0;
    else if (btn_press) press_count <= press_count + 8'd1;
  end

`ifdef PED_LONG_PRESS_EN
  logic [23:0] hold_cnt;

  // Hold counter is zero outside HELD, so it restarts on each entry;
  // it stops one past the target so the pulse happens only once
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              hold_cnt <= 24'd0;
    else if (state != HELD)               hold_cnt <= 24'd0;
    else if (hold_cnt < LONG_PRESS_CYCLES) hold_cnt <= hold_cnt + 24'd1;
  end

  // Long-press pulse when the hold counter hits its target
  always_comb begin
    long_press = (state == HELD) && (hold_cnt == LONG_PRESS_CYCLES - 24'd1);
  end
`endif

endmodule

// File: tb/tb_ped_button_ctrl.sv
// Directed testbench for ped_button_ctrl with DEBOUNCE_CYCLES=4 and
// LONG_PRESS_CYCLES=10. Inputs change 1 time unit after a rising edge and
// outputs are sampled at that same point, away from the edge.
module tb_ped_button_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       buton;
  logic       req_ack;
  logic       btn_level;
  logic       btn_press;
  logic       req_pending;
  logic [7:0] press_count;
`ifdef PED_LONG_PRESS_EN
  logic       long_press;
`endif

  int total = 0;
  int bad   = 0;

  ped_button_ctrl #(
    .DEBOUNCE_CYCLES   (16'd4),
    .LONG_PRESS_CYCLES (24'd10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .buton       (buton),
    .req_ack     (req_ack),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .req_pending (req_pending),
    .press_count (press_count)
`ifdef PED_LONG_PRESS_EN
    ,
    .long_press  (long_press)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold the button low for 'hold' edges, then release for 'rel' edges,
  // counting press pulses; optionally acknowledge in the press cycle
  task automatic do_press(input int hold, input int rel, input bit ack_on_press,
                          output int np, output int fk);
    np = 0;
    fk = -1;
    buton = 1'b0;
    for (int k = 1; k <= hold; k++) begin
      tick();
      if (btn_press) begin
        np++;
        if (fk < 0) fk = k;
      end
      req_ack = ack_on_press && btn_press;
    end
    req_ack = 1'b0;
    buton = 1'b1;
    for (int k = 1; k <= rel; k++) begin
      tick();
      if (btn_press) np++;
    end
    $display("press: hold=%0d pulses=%0d at=%0d count=%0d pending=%0d",
             hold, np, fk, press_count, req_pending);
  endtask

  initial begin
    int np;
    int fk;
    int lvl;
    int tot;

    rst = 1'b1;
    buton = 1'b1;
    req_ack = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_level", btn_level, 0);
    chk("rst_press", btn_press, 0);
    chk("rst_pending", req_pending, 0);
    chk("rst_count", press_count, 0);
    rst = 1'b0;
    tick();
    chk("idle_level", btn_level, 0);

    // Glitches of 1..3 cycles must be rejected
    for (int w = 1; w <= 3; w++) begin
      np = 0;
      lvl = 0;
      for (int k = 1; k <= w + 12; k++) begin
        buton = (k <= w) ? 1'b0 : 1'b1;
        tick();
        if (btn_press) np++;
        if (btn_level) lvl = 1;
      end
      $display("glitch: width=%0d pulses=%0d level=%0d", w, np, lvl);
      chk($sformatf("glitch%0d_press", w), np, 0);
      chk($sformatf("glitch%0d_level", w), lvl, 0);
      chk($sformatf("glitch%0d_count", w), press_count, 0);
    end

    // Clean press: pulse exactly 6 cycles after the edge
    buton = 1'b0;
    np = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (btn_press) np++;
      if (k == 5) chk("p1_press_k5", btn_press, 0);
      if (k == 6) begin
        chk("p1_press_k6", btn_press, 1);
        chk("p1_level_k6", btn_level, 0);
      end
      if (k == 7) begin
        chk("p1_press_k7", btn_press, 0);
        chk("p1_level_k7", btn_level, 1);
      end
    end
    $display("press: hold=20 pulses=%0d count=%0d", np, press_count);
    chk("p1_pulses", np, 1);
    chk("p1_count", press_count, 1);
    chk("p1_pending", req_pending, 1);
    buton = 1'b1;
    repeat (12) tick();
    chk("p1_release_level", btn_level, 0);

    // Acknowledge clears the request; a stray ack has no effect
    req_ack = 1'b1;
    tick();
    req_ack = 1'b0;
    $display("ack: pending=%0d", req_pending);
    chk("ack_clear", req_pending, 0);
    req_ack = 1'b1;
    tick();
    req_ack = 1'b0;
    chk("ack_idle", req_pending, 0);

    // Press and acknowledge in the same cycle keeps the request
    do_press(10, 10, 1'b1, np, fk);
    chk("sim_pulses", np, 1);
    chk("sim_at", fk, 6);
    chk("sim_pending", req_pending, 1);
    chk("sim_count", press_count, 2);

    // Reset two cycles into DB_PRESS with the button still held
    buton = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    #1;
    $display("midreset: level=%0d press=%0d pending=%0d count=%0d",
             btn_level, btn_press, req_pending, press_count);
    chk("mr_level", btn_level, 0);
    chk("mr_press", btn_press, 0);
    chk("mr_pending", req_pending, 0);
    chk("mr_count", press_count, 0);
    tick();
    rst = 1'b0;
    np = 0;
    fk = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (btn_press) begin
        np++;
        if (fk < 0) fk = k;
      end
    end
    $display("after reset: pulses=%0d at=%0d", np, fk);
    chk("mr_pulses", np, 1);
    chk("mr_at", fk, 6);
    chk("mr_count_after", press_count, 1);
    buton = 1'b1;
    repeat (12) tick();

    // 256 presses wrap the counter back to zero
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tot = 0;
    for (int i = 0; i < 256; i++) begin
      do_press(8, 10, 1'b0, np, fk);
      tot += np;
      if (i == 254) chk("wrap_count255", press_count, 255);
    end
    chk("wrap_pulses", tot, 256);
    chk("wrap_count", press_count, 0);

`ifdef PED_LONG_PRESS_EN
    // Long press with a short release bounce inside the hold
    rst = 1'b1;
    tick();
    rst = 1'b0;
    np = 0;
    tot = 0;
    fk = -1;
    lvl = 1;
    for (int k = 1; k <= 30; k++) begin
      buton = (k == 20 || k == 21) ? 1'b1 : 1'b0;
      tick();
      if (btn_press) np++;
      if (long_press) begin
        tot++;
        if (fk < 0) fk = k;
      end
      if (k >= 7 && !btn_level) lvl = 0;
    end
    $display("long: pulses=%0d long=%0d at=%0d", np, tot, fk);
    chk("lp_pulses", tot, 1);
    chk("lp_at", fk, 16);
    chk("lp_press", np, 1);
    chk("lp_level", lvl, 1);
    buton = 1'b1;
    repeat (12) tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ped_button_ctrl.md
PED_BUTTON_CTRL -- requirements
Module: ped_button_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16'd60_000 (5 ms at 12 MHz), stable cycles required to accept a level change; legal range 1..65535.
REQ-002 SHALL have parameter LONG_PRESS_CYCLES, default 24'd12_000_000 (1 s at 12 MHz), continuous held cycles for a long press.
REQ-003 SHALL have port clk  input  1  sole clock, all flops rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port buton  input  1  raw pedestrian pushbutton, active-low, asynchronous to clk.
REQ-006 SHALL have port req_ack  input  1  one-cycle acknowledge from the light controller when it accepts the crossing request.
REQ-007 SHALL have port btn_level  output  1  debounced level, 1 = pressed.
REQ-008 SHALL have port btn_press  output  1  one-cycle pulse per accepted press.
REQ-009 SHALL have port req_pending  output  1  sticky crossing request, held until acknowledged.
REQ-010 SHALL have port press_count  output  8  count of accepted presses.
REQ-011 SHALL have port long_press  output  1  one-cycle pulse, present only with PED_LONG_PRESS_EN.

Function
REQ-012 SHALL synchronise buton through two flops, reset value 1 (released); pressed_s = inverse of second flop.
REQ-013 SHALL implement FSM IDLE, DB_PRESS, HELD, DB_RELEASE with a 16-bit debounce counter.
REQ-014 IDLE: pressed_s=1 -> DB_PRESS, counter cleared.
REQ-015 DB_PRESS: pressed_s=0 -> IDLE; else counter increments; when counter reaches DEBOUNCE_CYCLES-1 with pressed_s=1 -> HELD and btn_press=1 for that one cycle.
REQ-016 HELD: pressed_s=0 -> DB_RELEASE, counter cleared.
REQ-017 DB_RELEASE: pressed_s=1 -> HELD (no new btn_press); counter reaching DEBOUNCE_CYCLES-1 with pressed_s=0 -> IDLE.
REQ-018 btn_level SHALL be 1 in HELD and DB_RELEASE, 0 otherwise (registered).
REQ-019 Latency: raw stable press -> btn_press exactly 2 + DEBOUNCE_CYCLES cycles later.
REQ-020 req_pending SHALL set on btn_press, clear on req_ack; simultaneous btn_press and req_ack -> req_pending stays 1; req_ack with req_pending=0 -> no effect.
REQ-021 press_count SHALL increment on every btn_press, wrapping 255 -> 0.
REQ-022 Glitches shorter than DEBOUNCE_CYCLES SHALL produce no btn_press, no btn_level change, no press_count change.
REQ-023 Counters SHALL saturate, never wrap, within a state.

Reset
REQ-024 rst=1 SHALL immediately force: FSM IDLE, counters 0, sync flops 1, btn_level 0, btn_press 0, req_pending 0, press_count 0, long_press 0.
REQ-025 Reset mid-debounce or mid-hold SHALL discard progress; after release of rst a still-held button SHALL be debounced afresh and produce one btn_press.

Configuration
REQ-026 Macro PED_LONG_PRESS_EN defined: 24-bit hold counter runs in HELD, cleared on entering HELD; on reaching LONG_PRESS_CYCLES-1 long_press pulses once per hold, then counter saturates.
REQ-027 Macro undefined: no long_press port, no hold counter; all other behaviour identical.

Structure
REQ-028 Shared package ped_pkg SHALL hold the FSM state typedef (2-bit encoding IDLE=0, DB_PRESS=1, HELD=2, DB_RELEASE=3) and default timing constants.
REQ-029 Sub-module sync_2ff (two-flop synchroniser, parameterised reset value) SHALL be instantiated for buton; everything else is flat.

Verification (DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10)
REQ-030 buton 1->0 held 20 cycles -> btn_press single pulse 6 cycles after the edge, btn_level=1, press_count=1, req_pending=1.
REQ-031 buton low pulses of 1, 2, 3 cycles -> no btn_press, btn_level stays 0, press_count stays 0.
REQ-032 req_pending=1, req_ack pulse -> req_pending=0 next cycle; btn_press and req_ack same cycle -> req_pending=1.
REQ-033 256 clean presses -> press_count wraps to 0, 256 btn_press pulses.
REQ-034 rst asserted 2 cycles into DB_PRESS while buton held low -> all outputs 0 at once; after rst release btn_press 6 cycles later, exactly once.
REQ-035 PED_LONG_PRESS_EN, press held 30 cycles -> one long_press pulse 10 cycles after entering HELD; release bounce of 2 cycles within hold -> no second btn_press.
